// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: supervises a fractional PLL from the 74.25 MHz reference
// domain. Pulses the PLL reset, waits for lock, requires lock to stay stable
// before releasing the core reset, and re-sequences on lock loss or request.
// Saturating status counters record lock timeouts and in-service lock losses.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 742500,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic             clk_74a,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             core_reset_n,
    output logic             pll_ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] timeout_count,
    output logic [CNT_W-1:0] loss_count
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Saturating increment: the status counters stick at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    localparam int MAX_CYC = max2(max2(RST_CYCLES, LOCK_TIMEOUT), STABLE_CYCLES);
    localparam int CW      = $clog2(MAX_CYC + 1);

    // The counter reads k-1 on the k-th edge spent in a state, so each
    // "last" value marks the edge that completes the required cycle count.
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             sync1_q, sync2_q;
    logic             pll_rst_q, core_rst_n_q, ready_q;
    logic             locked_s;

    assign locked_s = sync2_q;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, status-counter and cycle-counter logic.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        loss_d  = loss_q;
        case (state_q)
            S_RESET_PLL: begin
                // relock_req deliberately has no effect while already resetting
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = sat_inc(tmo_q);
                    state_d = S_RESET_PLL;
                end
                if (relock_req) state_d = S_RESET_PLL;
            end
            S_STABLE: begin
                // A dropout only restarts the wait; the PLL is not reset.
                if (!locked_s)              state_d = S_WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = S_RUN;
                if (relock_req) state_d = S_RESET_PLL;
            end
            S_RUN: begin
                if (!locked_s) begin
                    loss_d  = sat_inc(loss_q);
                    state_d = S_RESET_PLL;
                end
                if (relock_req) state_d = S_RESET_PLL;
            end
            default: state_d = S_RESET_PLL;
        endcase

        // Cleared on every state entry; parked in RUN where no timing is needed.
        if (state_d != state_q)    cnt_d = '0;
        else if (state_q != S_RUN) cnt_d = cnt_q + CW'(1);
        else                       cnt_d = cnt_q;
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // they change on the same edge as the state register.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= '0;
            tmo_q        <= '0;
            loss_q       <= '0;
            pll_rst_q    <= 1'b1;
            core_rst_n_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            loss_q       <= loss_d;
            pll_rst_q    <= (state_d == S_RESET_PLL);
            core_rst_n_q <= (state_d == S_RUN);
            ready_q      <= (state_d == S_RUN);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign core_reset_n  = core_rst_n_q;
    assign pll_ready     = ready_q;
    assign state         = state_q;
    assign timeout_count = tmo_q;
    assign loss_count    = loss_q;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Supervises the core's fractional PLL from the 74.25 MHz reference domain.
- Drives the PLL's active-high reset and watches its asynchronous `locked` output.
- Releases the core reset only after lock has been continuously stable, and forces the PLL back through reset on lock loss or on software request.
- Keeps saturating counters of lock timeouts and lock losses for status reporting over the bridge.

Parameters:
- RST_CYCLES, 16: cycles `pll_rst` is held high on each PLL reset pulse (≥1).
- LOCK_TIMEOUT, 742500: cycles to wait for lock before re-resetting the PLL (10 ms at 74.25 MHz, ≥2).
- STABLE_CYCLES, 1024: cycles lock must stay continuously high before core release (≥1).
- CNT_W, 8: width of the status counters.

Ports:
- clk_74a  in  1  74.25 MHz reference clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL `locked`, asynchronous; double-flop synchronised internally.
- relock_req  in  1  one-cycle pulse forcing a PLL re-reset.
- pll_rst  out  1  active-high reset to the PLL.
- core_reset_n  out  1  active-low reset for downstream core logic.
- pll_ready  out  1  high only in RUN.
- state  out  2  current state: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN.
- timeout_count  out  CNT_W  saturating count of lock timeouts.
- loss_count  out  CNT_W  saturating count of lock losses while in RUN.

Behaviour:
- **Registered outputs.** All outputs are registered.
- **Reset.**
  - reset_n low, asynchronously: state=RESET_PLL, pll_rst=1, core_reset_n=0, pll_ready=0, both counts=0, internal counter=0, sync flops=0.
  - Reset asserted mid-operation returns the block to this condition immediately, whatever state it was in.
- **Synchroniser.** locked_s is pll_locked after a 2-flop synchroniser (2-cycle latency). Only locked_s is used by the FSM.
- **Internal counter.** A single down-counter or up-counter (implementer's choice) is sized to hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). It is cleared on every state entry.
- **RESET_PLL.**
  - pll_rst=1, core_reset_n=0.
  - After exactly RST_CYCLES cycles in the state, go to WAIT_LOCK.
  - relock_req is ignored in this state.
- **WAIT_LOCK.**
  - pll_rst=0, core_reset_n=0.
  - locked_s=1: go to STABLE.
  - Otherwise the counter advances. On the LOCK_TIMEOUT-th cycle without lock: timeout_count+1 (saturating at all-ones), go to RESET_PLL.
- **STABLE.**
  - pll_rst=0, core_reset_n=0.
  - locked_s=0: go to WAIT_LOCK. The PLL is not reset and no counter increments.
  - Otherwise, after STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN.
- **RUN.**
  - pll_rst=0, core_reset_n=1, pll_ready=1.
  - locked_s=0: loss_count+1 (saturating), go to RESET_PLL.
  - core_reset_n and pll_ready fall and pll_rst rises on the same edge as the state change.
- **relock_req.**
  - In WAIT_LOCK, STABLE or RUN: go to RESET_PLL on the next edge. No counter increments.
  - If relock_req coincides with a lock loss in RUN: loss_count increments exactly once; go to RESET_PLL.
  - If relock_req coincides with the timeout cycle in WAIT_LOCK: timeout_count increments once; go to RESET_PLL.
- **Saturation.** Both counts hold at 2^CNT_W-1. They never wrap, and they are cleared only by reset_n.
- **Latency with lock already present.** If pll_locked is already high when reset_n releases, core_reset_n rises RST_CYCLES+1+STABLE_CYCLES cycles after the first edge with reset_n high.

Test Plan:
Directed scenarios run with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, CNT_W=2.
1. **Clean bring-up.** pll_locked held 1, release reset_n.
   - Required: pll_rst high for exactly 4 cycles.
   - Required: core_reset_n rises at cycle 13 after release; state sequence 0→1→2→3; both counts remain 0.
2. **Lock timeout and retry.** pll_locked held 0.
   - Required: pll_rst re-pulses for 4 cycles every 24 cycles.
   - Required: timeout_count steps 1, 2, 3, then holds at 3 on the 4th and later timeouts.
   - Required: core_reset_n stays 0 throughout.
3. **Glitch during STABLE.** Drop pll_locked low for 1 cycle midway through STABLE.
   - Required: state returns to 1 then 2, with no pll_rst pulse and no count change.
   - Required: core_reset_n rises 8 stable cycles after lock reappears.
4. **Lock loss in RUN.** Drop pll_locked while in RUN.
   - Required: 2 cycles later (synchroniser), then on the next edge: core_reset_n=0, pll_ready=0, pll_rst=1, loss_count=1.
   - Required: full re-sequence follows.
5. **Relock request.**
   - relock_req pulse in RUN → RESET_PLL next edge, counts unchanged.
   - relock_req pulse in RESET_PLL → ignored, pulse length still 4.
   - relock_req coincident with lock loss → loss_count +1 only.
6. **Asynchronous reset mid-STABLE.** Assert reset_n low between clock edges while in STABLE.
   - Required: outputs return to reset values before the next edge.
   - Required: counts cleared to 0.
